// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register IDs and default datapath width.
package y86_pkg;

  localparam int unsigned DEFAULT_DATA_W = 64;

  typedef logic [3:0] reg_id_t;

  localparam reg_id_t RRAX  = 4'h0;
  localparam reg_id_t RRCX  = 4'h1;
  localparam reg_id_t RRDX  = 4'h2;
  localparam reg_id_t RRBX  = 4'h3;
  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RRBP  = 4'h5;
  localparam reg_id_t RRSI  = 4'h6;
  localparam reg_id_t RRDI  = 4'h7;
  localparam reg_id_t RR8   = 4'h8;
  localparam reg_id_t RR9   = 4'h9;
  localparam reg_id_t RR10  = 4'hA;
  localparam reg_id_t RR11  = 4'hB;
  localparam reg_id_t RR12  = 4'hC;
  localparam reg_id_t RR13  = 4'hD;
  localparam reg_id_t RR14  = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  localparam int unsigned NUM_REGS = 15;

endpackage

// File: rtl/y86_regfile_rdport.sv
// One combinational register-file read port.
// Optional same-cycle write forwarding under Y86_REGFILE_BYPASS_EN.
module y86_regfile_rdport
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  reg_id_t           src,
`ifdef Y86_REGFILE_BYPASS_EN
  input  logic              wb_en,
  input  reg_id_t           dstE,
  input  logic [DATA_W-1:0] valE,
  input  reg_id_t           dstM,
  input  logic [DATA_W-1:0] valM,
`endif
  output logic [DATA_W-1:0] val
);

  // Read mux: "no register" reads zero; forwarded data beats storage, valM beats valE.
  always_comb begin
    val = '0;
    if (src != RNONE) begin
      val = regs[src];
`ifdef Y86_REGFILE_BYPASS_EN
      if (wb_en && dstM == src) begin
        val = valM;
      end else if (wb_en && dstE == src) begin
        val = valE;
      end
`endif
    end
  end

endmodule

// File: rtl/y86_regfile.sv
// Y86-64 SEQ register file: two combinational read ports, two write ports.
// Build option: define Y86_REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  reg_id_t           dstE,
  input  logic [DATA_W-1:0] valE,
  input  reg_id_t           dstM,
  input  logic [DATA_W-1:0] valM,
  input  reg_id_t           srcA,
  input  reg_id_t           srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              wr_conflict,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              e_valid;
  logic              m_valid;
  logic [15:0]       count_inc;

  // Number of distinct registers written by this commit.
  always_comb begin
    e_valid   = (dstE != RNONE);
    m_valid   = (dstM != RNONE);
    count_inc = 16'd0;
    if (e_valid && m_valid && dstE != dstM) begin
      count_inc = 16'd2;
    end else if (e_valid || m_valid) begin
      count_inc = 16'd1;
    end
  end

  // Storage and status update; M port written last so it wins on an ID collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
      end
      wr_conflict <= 1'b0;
      wr_count    <= 16'd0;
    end else if (wb_en) begin
      if (e_valid) begin
        regs[dstE] <= valE;
      end
      if (m_valid) begin
        regs[dstM] <= valM;
      end
      wr_conflict <= e_valid && m_valid && (dstE == dstM);
      wr_count    <= wr_count + count_inc;
    end
  end

  y86_regfile_rdport #(
    .DATA_W(DATA_W)
  ) u_rdport_a (
    .regs  (regs),
    .src   (srcA),
`ifdef Y86_REGFILE_BYPASS_EN
    .wb_en (wb_en),
    .dstE  (dstE),
    .valE  (valE),
    .dstM  (dstM),
    .valM  (valM),
`endif
    .val   (valA)
  );

  y86_regfile_rdport #(
    .DATA_W(DATA_W)
  ) u_rdport_b (
    .regs  (regs),
    .src   (srcB),
`ifdef Y86_REGFILE_BYPASS_EN
    .wb_en (wb_en),
    .dstE  (dstE),
    .valE  (valE),
    .dstM  (dstM),
    .valM  (valM),
`endif
    .val   (valB)
  );

endmodule

// File: tb/tb_y86_regfile.sv
// Self-checking bench for y86_regfile: directed steps plus a random phase
// checked against an array-based model of the register file.
`timescale 1ns/1ps
module tb_y86_regfile;

  localparam logic [63:0] RSP_INIT = 64'h200;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [3:0]  dstE, dstM, srcA, srcB;
  logic [63:0] valE, valM, valA, valB;
  logic        wr_conflict;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [63:0] m_regs [15];
  logic [15:0] m_count;
  logic        m_conf;

  always #5 clk = ~clk;

  y86_regfile #(
    .DATA_W   (64),
    .RSP_INIT (RSP_INIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_en       (wb_en),
    .dstE        (dstE),
    .valE        (valE),
    .dstM        (dstM),
    .valM        (valM),
    .srcA        (srcA),
    .srcB        (srcB),
    .valA        (valA),
    .valB        (valB),
    .wr_conflict (wr_conflict),
    .wr_count    (wr_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a read of src should return right now, given current inputs.
  function automatic logic [63:0] exp_read(input logic [3:0] src);
    if (src == 4'hF) return 64'h0;
`ifdef Y86_REGFILE_BYPASS_EN
    if (!reset && wb_en && dstM == src) return valM;
    if (!reset && wb_en && dstE == src) return valE;
`endif
    return m_regs[src];
  endfunction

  // Advance one clock edge and apply the same commit to the model.
  task automatic commit();
    int n;
    @(posedge clk);
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = (i == 4) ? RSP_INIT : 64'h0;
      m_count = 16'd0;
      m_conf  = 1'b0;
    end else if (wb_en) begin
      n = 0;
      if (dstE != 4'hF) begin m_regs[dstE] = valE; n++; end
      if (dstM != 4'hF) begin
        m_regs[dstM] = valM;
        if (dstM != dstE) n++;
      end
      m_conf  = (dstE != 4'hF) && (dstE == dstM);
      m_count = m_count + 16'(n);
    end
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, {48'h0, wr_count}, {48'h0, m_count});
    chk({tag, "_conf"}, {63'h0, wr_conflict}, {63'h0, m_conf});
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 64'hx;
    m_count = 16'hx;
    m_conf  = 1'bx;
    reset = 1'b1; wb_en = 1'b0;
    dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    srcA = 4'h4; srcB = 4'h0;
    #2;
    commit();
    commit();
    reset = 1'b0;

    // Reset state
    chk("rst_valA_rsp", valA, 64'h200);
    chk("rst_valB_rax", valB, 64'h0);
    check_status("rst");

    // Single E-port write, same-cycle read then post-edge read
    wb_en = 1'b1; dstE = 4'h3; valE = 64'h1234; dstM = 4'hF; srcA = 4'h3;
    #1;
`ifdef Y86_REGFILE_BYPASS_EN
    chk("samecyc_rbx", valA, 64'h1234);
`else
    chk("samecyc_rbx", valA, 64'h0);
`endif
    commit();
    chk("wr_rbx", valA, 64'h1234);
    check_status("wr1");

    // E and M target %rsp: M wins, conflict flagged
    dstE = 4'h4; valE = 64'h1F8; dstM = 4'h4; valM = 64'hABC; srcB = 4'h4;
    commit();
    wb_en = 1'b0;
    #1;
    chk("conflict_rsp", valB, 64'hABC);
    check_status("conflict");

    // Next commit without collision clears the flag
    wb_en = 1'b1; dstE = 4'h2; valE = 64'h77; dstM = 4'hF; srcA = 4'h2;
    commit();
    chk("wr_rdx", valA, 64'h77);
    check_status("clear_conf");

    // wb_en low: no write, status holds
    wb_en = 1'b0; dstE = 4'h1; valE = 64'h55; srcA = 4'h1;
    commit();
    chk("noen_rcx", valA, 64'h0);
    check_status("noen");

    // Both IDs none: no write, count holds
    wb_en = 1'b1; dstE = 4'hF; dstM = 4'hF;
    commit();
    check_status("none");

    // Random phase
    for (int k = 0; k < 300; k++) begin
      wb_en = ($urandom_range(0, 3) != 0);
      dstE  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      dstM  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      if ($urandom_range(0, 5) == 0) dstM = dstE;
      valE  = {$urandom, $urandom};
      valM  = {$urandom, $urandom};
      srcA  = 4'($urandom_range(0, 15));
      srcB  = (k % 7 == 0) ? dstE : 4'($urandom_range(0, 15));
      #1;
      chk("rnd_valA", valA, exp_read(srcA));
      chk("rnd_valB", valB, exp_read(srcB));
      commit();
      check_status("rnd");
    end

    // Drive the write counter up to 16'hFFFF with single writes
    wb_en = 1'b1; dstE = 4'h0; dstM = 4'hF; valE = 64'h1;
    while (m_count != 16'hFFFF) commit();
    check_status("preload");

    // Two distinct writes wrap the counter to 1
    dstE = 4'h5; valE = 64'hDEAD_0005; dstM = 4'h6; valM = 64'hBEEF_0006;
    srcA = 4'h5; srcB = 4'h6;
    commit();
    chk("wrap_count", {48'h0, wr_count}, 64'h1);
    chk("wrap_rbp", valA, 64'hDEAD_0005);
    chk("wrap_rsi", valB, 64'hBEEF_0006);
    check_status("wrap");

    // Reset overrides a concurrent write
    reset = 1'b1; wb_en = 1'b1; dstE = 4'h7; valE = 64'h99; dstM = 4'hF; srcA = 4'hF;
    #1;
    chk("rst2_pre_none", valA, 64'h0);
    commit();
    reset = 1'b0; wb_en = 1'b0; srcB = 4'h7;
    #1;
    chk("rst2_none", valA, 64'h0);
    chk("rst2_rdi", valB, 64'h0);
    srcB = 4'h4;
    #1;
    chk("rst2_rsp", valB, RSP_INIT);
    chk("rst2_count", {48'h0, wr_count}, 64'h0);
    check_status("rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y86_regfile.md
Name: y86_regfile

Overview:
- Y86-64 SEQ register file; consumes the write-back destination IDs (dstE, dstM) produced by decode/write-back logic, plus valE/valM from execute/memory.
- Provides two combinational read ports (srcA, srcB) to decode.
- Provides two synchronous write ports (E and M), committed on the rising clock edge at the end of each instruction.
- Register ID 4'hF means "no register": reads return 0, writes are discarded.

Parameters:
- DATA_W, 64, register data width.
- RSP_INIT, 64'h0, reset value of %rsp (ID 4); all other registers reset to 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_en  input  1  instruction commit strobe; writes occur only when 1 (0 on bubble/halt/error stat).
- dstE  input  4  destination ID for valE; 4'hF = none.
- valE  input  DATA_W  execute-stage result.
- dstM  input  4  destination ID for valM; 4'hF = none.
- valM  input  DATA_W  memory-stage result.
- srcA  input  4  read port A ID; 4'hF = none.
- srcB  input  4  read port B ID; 4'hF = none.
- valA  output  DATA_W  contents of register srcA.
- valB  output  DATA_W  contents of register srcB.
- wr_conflict  output  1  registered flag: last committed cycle had dstE == dstM != 4'hF.
- wr_count  output  16  registered count of committed register writes, wrapping.

Behaviour:
- Storage: 15 registers of DATA_W bits, IDs 0..14 (rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi, r8..r14).
- Reset (clk edge with reset=1):
  - All registers become 0, except ID 4, which becomes RSP_INIT.
  - wr_conflict = 0; wr_count = 0.
  - Reset overrides any write presented in the same cycle.
- Reads: purely combinational from current storage, zero latency.
  - src == 4'hF returns 0.
  - Without the bypass feature, a read in the same cycle as a write to the same ID returns the old value.
- Writes: on a rising edge with reset=0 and wb_en=1:
  - reg[dstE] <= valE if dstE != 4'hF.
  - reg[dstM] <= valM if dstM != 4'hF.
  - If dstE == dstM != 4'hF, valM wins (popq %rsp semantics); wr_conflict <= 1.
  - Otherwise wr_conflict <= 0.
- wr_count increment per committed edge:
  - +2 when both IDs are valid and different.
  - +1 when exactly one is valid, or both are valid and equal.
  - +0 otherwise.
  - Modulo 2^16; 16'hFFFF + 1 = 16'h0000, 16'hFFFF + 2 = 16'h0001.
- wb_en=0: no register writes; wr_conflict and wr_count hold their values.
- Write-port IDs 4'hF are discarded silently; there is no out-of-range ID (4 bits, 15 valid plus none).

Optional Feature:
- Macro: Y86_REGFILE_BYPASS_EN.
- Defined:
  - valA/valB forward same-cycle write data when wb_en=1 and src matches a valid dst.
  - Priority: valM over valE over storage.
- Undefined: reads see storage only; write data becomes visible the cycle after the edge.

Decomposition:
- Shared package y86_pkg:
  - Register ID constants: RRAX=0 .. RR14=14, RRSP=4, RNONE=4'hF.
  - DATA_W default.
  - Typedef reg_id_t (4 bits).
- One natural sub-module: y86_regfile_rdport.
  - Read mux with the RNONE check and the optional bypass compare.
  - Instantiated twice, for srcA and srcB.

Test Plan:
- Reset with RSP_INIT=64'h200, then srcA=4, srcB=0 -> valA=64'h200, valB=0, wr_count=0, wr_conflict=0.
- wb_en=1, dstE=3, valE=64'h1234, dstM=F -> after edge srcA=3 reads 64'h1234; wr_count=1.
  - Same-cycle read returns 0 without bypass, 64'h1234 with bypass.
- wb_en=1, dstE=4, valE=64'h1F8, dstM=4, valM=64'hABC -> reg4=64'hABC, wr_conflict=1, wr_count += 1.
  - Next commit with dstE=2, dstM=F -> wr_conflict=0.
- wb_en=0, dstE=1, valE=64'h55 -> reg1 unchanged and wr_count unchanged.
  - Then dstE=F, dstM=F with wb_en=1 -> no write, count unchanged.
- Preload wr_count to 16'hFFFF (via 65535 single writes), then dstE=5, dstM=6 distinct -> wr_count=16'h0001, reg5=valE, reg6=valM.
- Mid-run reset=1 while dstE=7, valE=64'h99, wb_en=1 -> reg7=0, reg4=RSP_INIT, wr_count=0; srcA=F reads 0 throughout.
